// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants: default widths, queue depth and the
// NOP word decode substitutes while no instruction is valid.
package instruction_fetch_pkg;

    localparam int IF_ADDR_W  = 8;
    localparam int IF_INSTR_W = 32;
    localparam int IF_DEPTH   = 2;

    localparam logic [IF_INSTR_W-1:0] IF_NOP = 32'h0000_0013;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// Clear empties it in one cycle; clear wins over push.
module instruction_fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int WIDTH = IF_INSTR_W + IF_ADDR_W,
    parameter int DEPTH = IF_DEPTH
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push_in,
    input  logic                     pop_in,
    input  logic                     clear_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_in) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_in) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_in) - CW'(pop_in);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_out  = mem_q[rd_ptr_q];
    assign valid_out = (count_q != '0);
    assign count_out = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues ROM reads under a credit limit, tracks the one
// in-flight read and buffers returned words for decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W,
    parameter int DEPTH   = IF_DEPTH
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [ADDR_W-1:0]      pc_in,
    input  logic                   flush_in,
    output logic                   pc_stall_out,
    output logic [ADDR_W-1:0]      imem_addr_out,
    output logic                   imem_rd_en_out,
    input  logic [INSTR_W-1:0]     imem_data_in,
    output logic [INSTR_W-1:0]     instr_out,
    output logic [ADDR_W-1:0]      instr_pc_out,
    output logic                   instr_valid_out,
    input  logic                   decode_ready_in,
    output logic [$clog2(DEPTH):0] occupancy_out
);

    localparam int CW = cnt_w(DEPTH);

    logic              inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CW:0]       outstanding;

    assign pop = instr_valid_out & decode_ready_in;

    // Words owed after this cycle's pop; one spare bit avoids overflow.
    assign outstanding = {1'b0, occupancy_out}
                       + (CW+1)'(inflight_v_q)
                       - (CW+1)'(pop);

    assign issue = rst_n_in & ~flush_in
                 & (outstanding < (CW+1)'(DEPTH));

    // A taken branch must let the PC load its target.
    assign pc_stall_out   = ~issue & ~(flush_in & rst_n_in);
    assign imem_addr_out  = pc_in;
    assign imem_rd_en_out = issue;

    assign push = inflight_v_q & ~flush_in;

    always_comb begin
        inflight_v_d  = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            inflight_pc_d = pc_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    instruction_fetch_queue #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push_in   (push),
        .pop_in    (pop),
        .clear_in  (flush_in),
        .data_in   ({imem_data_in, inflight_pc_q}),
        .data_out  ({instr_out, instr_pc_out}),
        .valid_out (instr_valid_out),
        .count_out (occupancy_out)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed per-cycle vector bench for instruction_fetch with a PC
// model, synchronous ROM model and delivered-PC scoreboard.
module tb_instruction_fetch;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;
    localparam int NVEC    = 37;

    logic               clk = 1'b0;
    logic               rst_n_in;
    logic [ADDR_W-1:0]  pc_in;
    logic               flush_in;
    logic               pc_stall_out;
    logic [ADDR_W-1:0]  imem_addr_out;
    logic               imem_rd_en_out;
    logic [INSTR_W-1:0] imem_data_in;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc_out;
    logic               instr_valid_out;
    logic               decode_ready_in;
    logic [1:0]         occupancy_out;

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n_in),
        .pc_in           (pc_in),
        .flush_in        (flush_in),
        .pc_stall_out    (pc_stall_out),
        .imem_addr_out   (imem_addr_out),
        .imem_rd_en_out  (imem_rd_en_out),
        .imem_data_in    (imem_data_in),
        .instr_out       (instr_out),
        .instr_pc_out    (instr_pc_out),
        .instr_valid_out (instr_valid_out),
        .decode_ready_in (decode_ready_in),
        .occupancy_out   (occupancy_out)
    );

    // Synchronous ROM: word = 0xA000_0000 | address
    always @(posedge clk) begin
        if (imem_rd_en_out)
            imem_data_in <= 32'hA000_0000 | {24'h0, imem_addr_out};
    end

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic [7:0] tgt;
        logic       ready;
        logic       ev;
        logic [7:0] epc;
        logic [1:0] eocc;
        logic       estall;
    } vec_t;

    vec_t vecs [NVEC];
    int   errors = 0;
    int   checks = 0;

    logic [7:0] got_pcs [$];
    logic [7:0] exp_pcs [$];

    logic       prev_stall;
    logic       prev_flush;
    logic [7:0] prev_tgt;
    logic       prev_rd;

    function automatic vec_t mk(input logic r, input logic f,
                                input logic [7:0] t, input logic rd,
                                input logic v, input logic [7:0] p,
                                input logic [1:0] o, input logic s);
        vec_t x;
        x.rst_n = r; x.flush = f; x.tgt = t; x.ready = rd;
        x.ev = v; x.epc = p; x.eocc = o; x.estall = s;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic pop;
        @(posedge clk);
        #1;
        // PC model: load target on flush, hold on stall, else step
        if (prev_flush)      pc_in = prev_tgt;
        else if (!prev_stall) pc_in = pc_in + 8'd1;
        rst_n_in        = v.rst_n;
        flush_in        = v.flush;
        decode_ready_in = v.ready;
        @(negedge clk);
        chk($sformatf("v%0d valid", k), 32'(instr_valid_out), 32'(v.ev));
        chk($sformatf("v%0d occ", k), 32'(occupancy_out), 32'(v.eocc));
        chk($sformatf("v%0d stall", k), 32'(pc_stall_out), 32'(v.estall));
        if (v.ev || !v.rst_n)
            chk($sformatf("v%0d pc", k), 32'(instr_pc_out), 32'(v.epc));
        if (!v.rst_n) begin
            chk($sformatf("v%0d rst instr", k), instr_out, 32'h0);
            chk($sformatf("v%0d rst rd_en", k), 32'(imem_rd_en_out), 32'h0);
        end
        pop = instr_valid_out & decode_ready_in;
        if (rst_n_in) begin
            checks++;
            if (prev_rd && !flush_in && !pop && occupancy_out == 2'(DEPTH)) begin
                errors++;
                $display("FAIL v%0d overflow: occ %0d with push pending", k,
                         occupancy_out);
            end
        end
        if (pop) begin
            chk($sformatf("v%0d word", k), instr_out,
                32'hA000_0000 | {24'h0, instr_pc_out});
            got_pcs.push_back(instr_pc_out);
        end
        chk($sformatf("v%0d addr", k), 32'(imem_addr_out), 32'(pc_in));
        prev_stall = pc_stall_out;
        prev_flush = flush_in;
        prev_tgt   = v.tgt;
        prev_rd    = imem_rd_en_out;
    endtask

    initial begin
        //             rst f  tgt    rdy v  pc     occ st
        vecs[0]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
        vecs[1]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[2]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0, 8'h00, 1, 1, 8'h00, 1, 0);
        vecs[4]  = mk(1, 0, 8'h00, 1, 1, 8'h01, 1, 0);
        vecs[5]  = mk(1, 0, 8'h00, 1, 1, 8'h02, 1, 0);
        vecs[6]  = mk(1, 0, 8'h00, 0, 1, 8'h03, 1, 1);
        vecs[7]  = mk(1, 0, 8'h00, 0, 1, 8'h03, 2, 1);
        vecs[8]  = mk(1, 0, 8'h00, 0, 1, 8'h03, 2, 1);
        vecs[9]  = mk(1, 0, 8'h00, 0, 1, 8'h03, 2, 1);
        vecs[10] = mk(1, 0, 8'h00, 0, 1, 8'h03, 2, 1);
        vecs[11] = mk(1, 0, 8'h00, 1, 1, 8'h03, 2, 0);
        vecs[12] = mk(1, 0, 8'h00, 1, 1, 8'h04, 1, 0);
        vecs[13] = mk(1, 0, 8'h00, 1, 1, 8'h05, 1, 0);
        vecs[14] = mk(1, 1, 8'h40, 0, 1, 8'h06, 1, 0);
        vecs[15] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[16] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[17] = mk(1, 0, 8'h00, 0, 1, 8'h40, 1, 1);
        vecs[18] = mk(1, 0, 8'h00, 0, 1, 8'h40, 2, 1);
        vecs[19] = mk(1, 1, 8'h80, 1, 1, 8'h40, 2, 0);
        vecs[20] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[21] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[22] = mk(1, 0, 8'h00, 1, 1, 8'h80, 1, 0);
        vecs[23] = mk(1, 1, 8'hFE, 1, 1, 8'h81, 1, 0);
        vecs[24] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[25] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[26] = mk(1, 0, 8'h00, 1, 1, 8'hFE, 1, 0);
        vecs[27] = mk(1, 0, 8'h00, 1, 1, 8'hFF, 1, 0);
        vecs[28] = mk(1, 0, 8'h00, 1, 1, 8'h00, 1, 0);
        vecs[29] = mk(1, 0, 8'h00, 0, 1, 8'h01, 1, 1);
        vecs[30] = mk(1, 0, 8'h00, 0, 1, 8'h01, 2, 1);
        vecs[31] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
        vecs[32] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
        vecs[33] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[34] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[35] = mk(1, 0, 8'h00, 1, 1, 8'h03, 1, 0);
        vecs[36] = mk(1, 0, 8'h00, 1, 1, 8'h04, 1, 0);

        exp_pcs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h40,
                    8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h03, 8'h04};

        rst_n_in        = 1'b1;
        pc_in           = '0;
        flush_in        = 1'b0;
        decode_ready_in = 1'b0;
        prev_stall      = 1'b1;
        prev_flush      = 1'b0;
        prev_tgt        = '0;
        prev_rd         = 1'b0;
        #2 rst_n_in = 1'b0;

        for (int k = 0; k < NVEC; k++) begin
            run_vec(k, vecs[k]);
        end

        chk("delivered count", 32'(got_pcs.size()), 32'(exp_pcs.size()));
        for (int i = 0; i < exp_pcs.size(); i++) begin
            if (i < got_pcs.size())
                chk($sformatf("delivered[%0d]", i), 32'(got_pcs[i]),
                    32'(exp_pcs[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
